// File: rtl/sub_32bit_serial_if.sv
// Operand/result handshake bundle for the sliced serial subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface sub_32bit_serial_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow_out, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow_out, busy
   );
endinterface

// File: rtl/sub_32bit_serial.sv
// Unsigned a - b computed one SLICE-bit slice per clock, LSB first,
// with the borrow registered between slices.
module sub_32bit_serial #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input logic                clk,
   input logic                rst_n,
   sub_32bit_serial_if.slave  bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             borrow_q, borrow_d;
   logic             borrow_out_q, borrow_out_d;

   logic [SLICE-1:0] a_slices [NSLICE];
   logic [SLICE-1:0] b_slices [NSLICE];
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE:0]   sl_res;

   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_q[gi*SLICE +: SLICE];
   end

   assign a_sl = a_slices[idx_q];
   assign b_sl = b_slices[idx_q];
   // Extra MSB of the SLICE+1-bit difference is the borrow into the next slice.
   assign sl_res = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      diff_d       = diff_q;
      idx_d        = idx_q;
      borrow_d     = borrow_q;
      borrow_out_d = borrow_out_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d      = bus.a;
               b_d      = bus.b;
               diff_d   = '0;
               idx_d    = '0;
               borrow_d = 1'b0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < NSLICE; i++) begin
               if (idx_q == IDXW'(i)) begin
                  diff_d[i*SLICE +: SLICE] = sl_res[SLICE-1:0];
               end
            end
            borrow_d = sl_res[SLICE];
            idx_d    = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               idx_d        = '0;
               borrow_out_d = sl_res[SLICE];
               state_d      = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         idx_q        <= '0;
         borrow_q     <= 1'b0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         diff_q       <= diff_d;
         idx_q        <= idx_d;
         borrow_q     <= borrow_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q == BUSY);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_sub_32bit_serial.sv
// Self-checking bench: directed vector table, back-pressure and reset corner
// cases, then a random stream checked against plain a-b / a<b arithmetic.
module tb_sub_32bit_serial;
   localparam int WIDTH  = 32;
   localparam int NSLICE = 4;
   localparam int NVEC   = 9;
   localparam int NSTREAM = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sub_32bit_serial_if #(.WIDTH(WIDTH)) bus ();

   sub_32bit_serial #(.WIDTH(WIDTH), .SLICE(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_diff;
      logic        exp_borrow;
   } vec_t;

   vec_t vecs [NVEC];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at a sample point with the block idle and out_ready high.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_b);
      int cyc;
      check({name, " in_ready"}, 64'(bus.in_ready), 64'(1));
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      check({name, " busy"}, 64'(bus.busy), 64'(1));
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check({name, " latency"}, 64'(cyc), 64'(NSLICE));
      check({name, " diff"}, 64'(bus.diff), 64'(exp_d));
      check({name, " borrow"}, 64'(bus.borrow_out), 64'(exp_b));
      $display("%s: a=%08h b=%08h diff=%08h borrow=%0b latency=%0d",
               name, a, b, bus.diff, bus.borrow_out, cyc);
      tick();
      check({name, " in_ready_after"}, 64'(bus.in_ready), 64'(1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
      vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
      vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[3] = '{32'h1234_5678, 32'h0102_0304, 32'h1132_5374, 1'b0};
      vecs[4] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0};
      vecs[5] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0};
      vecs[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1};
      vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
      vecs[8] = '{32'h00FF_0000, 32'h0100_0000, 32'hFFFF_0000, 1'b1};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0;
      bus.b = '0;

      #2;
      check("reset in_ready", 64'(bus.in_ready), 64'(1));
      check("reset out_valid", 64'(bus.out_valid), 64'(0));
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset diff", 64'(bus.diff), 64'(0));
      check("reset borrow", 64'(bus.borrow_out), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < NVEC; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow);
      end

      // Back-pressure: result held while out_ready is low, new operands refused.
      begin
         int cyc;
         bus.out_ready = 1'b0;
         bus.a = 32'h1234_5678;
         bus.b = 32'h0102_0304;
         bus.in_valid = 1'b1;
         tick();
         bus.a = 32'hDEAD_BEEF;
         bus.b = 32'h0BAD_F00D;
         cyc = 0;
         while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
         end
         check("bp latency", 64'(cyc), 64'(NSLICE));
         check("bp diff", 64'(bus.diff), 64'(32'h1132_5374));
         for (int k = 0; k < 3; k++) begin
            tick();
            check("bp hold out_valid", 64'(bus.out_valid), 64'(1));
            check("bp hold diff", 64'(bus.diff), 64'(32'h1132_5374));
            check("bp hold borrow", 64'(bus.borrow_out), 64'(0));
            check("bp hold in_ready", 64'(bus.in_ready), 64'(0));
         end
         bus.out_ready = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         check("bp release in_ready", 64'(bus.in_ready), 64'(1));
         check("bp release out_valid", 64'(bus.out_valid), 64'(0));
         $display("backpressure: diff=32'h11325374 held 3 cycles, released");
         tick();
      end

      // Asynchronous reset during the second compute cycle.
      begin
         int spurious;
         bus.a = 32'hFFFF_FFFF;
         bus.b = 32'h0000_0001;
         bus.in_valid = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         tick();
         #1;
         rst_n = 1'b0;
         #1;
         check("midrst in_ready", 64'(bus.in_ready), 64'(1));
         check("midrst out_valid", 64'(bus.out_valid), 64'(0));
         check("midrst busy", 64'(bus.busy), 64'(0));
         check("midrst diff", 64'(bus.diff), 64'(0));
         check("midrst borrow", 64'(bus.borrow_out), 64'(0));
         #1;
         rst_n = 1'b1;
         spurious = 0;
         for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid) spurious++;
         end
         check("midrst no out_valid", 64'(spurious), 64'(0));
         $display("midreset: in-flight 0xFFFFFFFF-1 discarded");
         run_op("post_reset", 32'd5, 32'd3, 32'd2, 1'b0);
      end

      // Random stream with in_valid and out_ready permanently high.
      begin
         logic [31:0] qa [$];
         logic [31:0] qb [$];
         logic [31:0] ea, eb, ed;
         int pushed, done, cyc, last_acc, busy_cnt, r;
         bit accepted;
         pushed = 0; done = 0; cyc = 0; last_acc = -1; busy_cnt = 0;
         bus.out_ready = 1'b1;
         bus.a = $urandom;
         bus.b = $urandom;
         bus.in_valid = 1'b1;
         while (done < NSTREAM && cyc < 20000) begin
            accepted = 1'b0;
            if (bus.in_ready && bus.in_valid) begin
               if (last_acc >= 0) check("stream spacing", 64'(cyc - last_acc), 64'(NSLICE + 2));
               last_acc = cyc;
               qa.push_back(bus.a);
               qb.push_back(bus.b);
               pushed++;
               accepted = 1'b1;
            end
            tick();
            cyc++;
            if (accepted) begin
               if (pushed < NSTREAM) begin
                  r = $urandom_range(0, 7);
                  bus.a = $urandom;
                  bus.b = (r == 0) ? bus.a : (r == 1) ? bus.a + 32'd1 : 32'($urandom);
               end else begin
                  bus.in_valid = 1'b0;
               end
            end
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
               if (qa.size() == 0) begin
                  check("stream spurious out_valid", 64'(1), 64'(0));
               end else begin
                  ea = qa.pop_front();
                  eb = qb.pop_front();
                  ed = ea - eb;
                  check("stream diff", 64'(bus.diff), 64'(ed));
                  check("stream borrow", 64'(bus.borrow_out), 64'(ea < eb));
                  check("stream busy cycles", 64'(busy_cnt), 64'(NSLICE));
                  $display("stream%0d: a=%08h b=%08h diff=%08h borrow=%0b",
                           done, ea, eb, bus.diff, bus.borrow_out);
               end
               busy_cnt = 0;
               done++;
            end
         end
         if (done < NSTREAM) check("stream timeout results", 64'(done), 64'(NSTREAM));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
